// File: rtl/indicator_sequencer.sv
// Turns the capture FSM's one-hot button state into left/right 3-lamp sweep/blink animations.
// Latency: sel sampled at edge n sets mode/err/lamps after edge n; lamps decode from registered state.
// Backpressure: none; sel is consumed every cycle and outputs are free-running.
module indicator_sequencer #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] sel,
  output logic [2:0] l_lamp,
  output logic [2:0] r_lamp,
  output logic [2:0] mode,
  output logic       err,
  output logic       wrap
);

  typedef enum logic [2:0] {
    M_IDLE   = 3'd0,
    M_LSWEEP = 3'd1,
    M_LBLINK = 3'd2,
    M_RSWEEP = 3'd3,
    M_RBLINK = 3'd4
  } mode_t;

  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

  mode_t      mode_q, mode_d, mode_dec;
  logic       err_q, err_d, err_dec;
  logic [7:0] presc_q, presc_d;
  logic [1:0] step_q, step_d;
  logic       wrap_q, wrap_d;

  // Decode the sel vector into a requested mode; multi-hot vectors fall back to idle with err.
  always_comb begin
    mode_dec = M_IDLE;
    err_dec  = 1'b0;
    case (sel)
      5'b00000, 5'b00001: mode_dec = M_IDLE;
      5'b00010:           mode_dec = M_LSWEEP;
      5'b00100:           mode_dec = M_LBLINK;
      5'b01000:           mode_dec = M_RSWEEP;
      5'b10000:           mode_dec = M_RBLINK;
      default:            err_dec  = 1'b1;
    endcase
  end

  // Next-state: a mode change restarts the animation; idle holds counters; otherwise step every DIV cycles.
  always_comb begin
    mode_d  = mode_q;
    err_d   = err_dec;
    presc_d = presc_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    if (mode_dec != mode_q) begin
      mode_d  = mode_dec;
      presc_d = 8'd0;
      step_d  = 2'd0;
    end else if (mode_q == M_IDLE) begin
      presc_d = 8'd0;
      step_d  = 2'd0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = 8'd0;
      step_d  = step_q + 2'd1;
      wrap_d  = (step_q == 2'd3);
    end else begin
      presc_d = presc_q + 8'd1;
    end
  end

  // State register; reset acts immediately so lamps go dark mid-animation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= M_IDLE;
      err_q   <= 1'b0;
      presc_q <= 8'd0;
      step_q  <= 2'd0;
      wrap_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      err_q   <= err_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  // Lamp decode from registered mode/step only, so sel glitches never reach the lamps directly.
  always_comb begin
    logic [2:0] sweep_pat;
    logic [2:0] blink_pat;
    case (step_q)
      2'd0:    sweep_pat = 3'b001;
      2'd1:    sweep_pat = 3'b011;
      2'd2:    sweep_pat = 3'b111;
      default: sweep_pat = 3'b000;
    endcase
    blink_pat = step_q[1] ? 3'b000 : 3'b111;
    l_lamp = 3'b000;
    r_lamp = 3'b000;
    case (mode_q)
      M_LSWEEP: l_lamp = sweep_pat;
      M_LBLINK: l_lamp = blink_pat;
      M_RSWEEP: r_lamp = sweep_pat;
      M_RBLINK: r_lamp = blink_pat;
      default:  ;
    endcase
  end

  assign mode = mode_q;
  assign err  = err_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_indicator_sequencer.sv
// Bench for indicator_sequencer: directed test-plan sequences then random sel runs,
// checked every cycle against a model that tracks cycles-since-mode-entry for DIV=4 and DIV=1.
module tb_indicator_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] sel;

  logic [2:0] l4, r4, m4, l1, r1, m1;
  logic       e4, w4, e1, w1;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  // model state per instance: current mode and cycles elapsed since the mode was entered
  int mm [2];
  int kk [2];
  int merr;
  int divs [2];

  always #5 clk = ~clk;

  indicator_sequencer #(.DIV(4)) dut4 (
    .clk(clk), .reset(reset), .sel(sel),
    .l_lamp(l4), .r_lamp(r4), .mode(m4), .err(e4), .wrap(w4)
  );

  indicator_sequencer #(.DIV(1)) dut1 (
    .clk(clk), .reset(reset), .sel(sel),
    .l_lamp(l1), .r_lamp(r1), .mode(m1), .err(e1), .wrap(w1)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, got, exp);
    end
  endtask

  // requested mode = index of the single set bit (bits 1..4); anything else is idle
  function automatic int dec_mode(input logic [4:0] s);
    if ($countones(s) != 1 || s == 5'b00001) return 0;
    for (int i = 1; i < 5; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mm[d] = 0;
      kk[d] = 0;
    end
    merr = 0;
  endtask

  task automatic model_edge();
    int dm;
    dm = dec_mode(sel);
    for (int d = 0; d < 2; d++) begin
      if (dm != mm[d]) begin
        mm[d] = dm;
        kk[d] = 0;
      end else if (mm[d] != 0) begin
        kk[d]++;
      end
    end
    merr = ($countones(sel) > 1) ? 1 : 0;
  endtask

  task automatic check_all();
    logic [2:0] sweep_tab [4];
    int st, pat, exp_l, exp_r, exp_w;
    sweep_tab[0] = 3'b001; sweep_tab[1] = 3'b011;
    sweep_tab[2] = 3'b111; sweep_tab[3] = 3'b000;
    for (int d = 0; d < 2; d++) begin
      st = (kk[d] / divs[d]) % 4;
      pat = (mm[d] == 1 || mm[d] == 3) ? int'(sweep_tab[st]) : ((st < 2) ? 7 : 0);
      exp_l = (mm[d] == 1 || mm[d] == 2) ? pat : 0;
      exp_r = (mm[d] == 3 || mm[d] == 4) ? pat : 0;
      exp_w = (mm[d] != 0 && kk[d] != 0 && (kk[d] % (4 * divs[d])) == 0) ? 1 : 0;
      if (d == 0) begin
        check("div4_mode", int'(m4), mm[d]);
        check("div4_err", int'(e4), merr);
        check("div4_wrap", int'(w4), exp_w);
        check("div4_l_lamp", int'(l4), exp_l);
        check("div4_r_lamp", int'(r4), exp_r);
      end else begin
        check("div1_mode", int'(m1), mm[d]);
        check("div1_err", int'(e1), merr);
        check("div1_wrap", int'(w1), exp_w);
        check("div1_l_lamp", int'(l1), exp_l);
        check("div1_r_lamp", int'(r1), exp_r);
      end
    end
  endtask

  // one clock: DUT and model both sample sel at the edge, outputs are compared 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    check_all();
  endtask

  task automatic run(input logic [4:0] s, input int n);
    sel = s;
    repeat (n) tick();
  endtask

  // assert reset between edges and confirm outputs clear before the next edge
  task automatic mid_cycle_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [4:0] pick_tab [7];
    logic [4:0] s;
    int r;
    divs[0] = 4;
    divs[1] = 1;
    pick_tab[0] = 5'b00000; pick_tab[1] = 5'b00001; pick_tab[2] = 5'b00010;
    pick_tab[3] = 5'b00100; pick_tab[4] = 5'b01000; pick_tab[5] = 5'b10000;
    pick_tab[6] = 5'b00110;

    reset = 1'b1;
    sel = 5'b00000;
    #12;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;

    run(5'b00000, 10);
    run(5'b00010, 20);
    run(5'b10000, 16);
    run(5'b01000, 9);
    run(5'b00100, 6);
    run(5'b00110, 3);
    run(5'b00010, 5);
    run(5'b00000, 2);
    run(5'b00010, 6);
    mid_cycle_reset();
    run(5'b00010, 8);
    run(5'b00001, 3);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) s = pick_tab[r];
      else s = 5'($urandom_range(0, 31));
      run(s, $urandom_range(1, 20));
      if ($urandom_range(0, 29) == 0) mid_cycle_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
